// File: rtl/ov7670_capture_if.sv
// Frame-buffer write port: single-cycle strobe carrying a word address and a 12-bit pixel.
interface ov7670_capture_if #(
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_buf      = 12
);
    logic                     frame_we;
    logic [c_nb_img_pxls-1:0] frame_wr_addr;
    logic [c_nb_buf-1:0]      frame_wr_pixel;

    modport master (output frame_we, frame_wr_addr, frame_wr_pixel);
    modport slave  (input  frame_we, frame_wr_addr, frame_wr_pixel);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 capture: synchronizes the camera bus, assembles 2-byte pixels, decimates and writes the frame buffer.
// Optional CAM_LINE_CHECK_EN adds a sticky line_err output flagging lines with a wrong pixel count.
module ov7670_capture #(
    parameter int unsigned c_cam_cols    = 640,
    parameter int unsigned c_cam_rows    = 480,
    parameter int unsigned c_dec_log2    = 3,
    parameter int unsigned c_img_cols    = c_cam_cols >> c_dec_log2,
    parameter int unsigned c_img_rows    = c_cam_rows >> c_dec_log2,
    parameter int unsigned c_img_pxls    = c_img_cols * c_img_rows,
    parameter int unsigned c_nb_img_pxls = 13,
    parameter int unsigned c_nb_buf      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cam_pclk,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic [7:0]           cam_data,
    input  logic                 rgbmode,
    input  logic                 testmode,
    ov7670_capture_if.master     fb,
    output logic                 frame_done,
    output logic                 capturing
`ifdef CAM_LINE_CHECK_EN
    ,
    output logic                 line_err
`endif
);
    // One spare bit so overlong lines/frames saturate well above the active limits
    localparam int unsigned c_nb_col = $clog2(c_cam_cols) + 1;
    localparam int unsigned c_nb_row = $clog2(c_cam_rows) + 1;

    localparam logic [c_nb_col-1:0]      c_col_lim  = c_nb_col'(c_cam_cols);
    localparam logic [c_nb_row-1:0]      c_row_lim  = c_nb_row'(c_cam_rows);
    localparam logic [c_nb_img_pxls-1:0] c_pxl_lim  = c_nb_img_pxls'(c_img_pxls);
    localparam logic [6:0]               c_bar1     = 7'(c_img_cols / 4);
    localparam logic [6:0]               c_bar2     = 7'(c_img_cols / 2);
    localparam logic [6:0]               c_bar3     = 7'((3 * c_img_cols) / 4);

    typedef enum logic [1:0] {IDLE, VSYNC, FRAME} state_t;

    state_t                   state;
    logic                     pclk_s1, pclk_s2, pclk_s3;
    logic                     vsync_s1, vsync_s2, vsync_s3;
    logic                     href_s1, href_s2, href_prev;
    logic [7:0]               data_s1, data_s2;
    logic [7:0]               b0;
    logic                     byte_phase;
    logic                     mode_rgb, mode_test;
    logic [c_nb_col-1:0]      cam_col;
    logic [c_nb_row-1:0]      cam_row;
    logic [c_nb_img_pxls-1:0] wr_cnt;

    logic                     pclk_rise_c, vsync_rise_c, vsync_fall_c, write_c;
    logic [6:0]               out_col_c;
    logic [11:0]              pixel_c;

    // Two-flop synchronizers; the extra pclk/vsync stage is for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_s1  <= 1'b0; pclk_s2  <= 1'b0; pclk_s3  <= 1'b0;
            vsync_s1 <= 1'b0; vsync_s2 <= 1'b0; vsync_s3 <= 1'b0;
            href_s1  <= 1'b0; href_s2  <= 1'b0;
            data_s1  <= '0;   data_s2  <= '0;
        end else begin
            pclk_s1  <= cam_pclk;  pclk_s2  <= pclk_s1;  pclk_s3  <= pclk_s2;
            vsync_s1 <= cam_vsync; vsync_s2 <= vsync_s1; vsync_s3 <= vsync_s2;
            href_s1  <= cam_href;  href_s2  <= href_s1;
            data_s1  <= cam_data;  data_s2  <= data_s1;
        end
    end

    assign pclk_rise_c  = pclk_s2 & ~pclk_s3;
    assign vsync_rise_c = vsync_s2 & ~vsync_s3;
    assign vsync_fall_c = vsync_s3 & ~vsync_s2;
    assign out_col_c    = 7'(cam_col >> c_dec_log2);

    // Keep one pixel of every 2^dec x 2^dec block while the buffer has room
    assign write_c = (state == FRAME) && pclk_rise_c && href_s2 && byte_phase
                  && (cam_col[c_dec_log2-1:0] == '0) && (cam_row[c_dec_log2-1:0] == '0)
                  && (cam_col < c_col_lim) && (cam_row < c_row_lim) && (wr_cnt < c_pxl_lim);

    // Word formatting; b1 is the byte currently on data_s2
    always_comb begin
        pixel_c = '0;
        if (mode_test) begin
            if (mode_rgb) begin
                if (out_col_c < c_bar1)      pixel_c = 12'hF00;
                else if (out_col_c < c_bar2) pixel_c = 12'h0F0;
                else if (out_col_c < c_bar3) pixel_c = 12'h00F;
                else                         pixel_c = 12'hFFF;
            end else begin
                pixel_c = {4'h0, out_col_c[6:3], 4'h0};
            end
        end else if (mode_rgb) begin
            pixel_c = {b0[3:0], data_s2};
        end else begin
            pixel_c = {4'h0, b0[7:4], 4'h0};
        end
    end

    // Frame FSM, byte assembly and write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            fb.frame_we       <= 1'b0;
            fb.frame_wr_addr  <= '0;
            fb.frame_wr_pixel <= '0;
            frame_done        <= 1'b0;
            capturing         <= 1'b0;
            href_prev         <= 1'b0;
            b0                <= '0;
            byte_phase        <= 1'b0;
            mode_rgb          <= 1'b0;
            mode_test         <= 1'b0;
            cam_col           <= '0;
            cam_row           <= '0;
            wr_cnt            <= '0;
`ifdef CAM_LINE_CHECK_EN
            line_err          <= 1'b0;
`endif
        end else begin
            fb.frame_we <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                IDLE: if (vsync_s2) state <= VSYNC;
                VSYNC: begin
                    if (vsync_fall_c) begin
                        wr_cnt     <= '0;
                        cam_row    <= '0;
                        cam_col    <= '0;
                        byte_phase <= 1'b0;
                        mode_rgb   <= rgbmode;
                        mode_test  <= testmode;
                        capturing  <= 1'b1;
                        state      <= FRAME;
                    end
                end
                FRAME: begin
                    if (vsync_rise_c) begin
                        frame_done <= 1'b1;
                        capturing  <= 1'b0;
                        state      <= VSYNC;
                    end else if (pclk_rise_c) begin
                        if (href_s2) begin
                            if (!byte_phase) begin
                                b0         <= data_s2;
                                byte_phase <= 1'b1;
                            end else begin
                                byte_phase <= 1'b0;
                                if (cam_col != '1) cam_col <= cam_col + 1'b1;
                                if (write_c) begin
                                    fb.frame_we       <= 1'b1;
                                    fb.frame_wr_addr  <= wr_cnt;
                                    fb.frame_wr_pixel <= c_nb_buf'(pixel_c);
                                    wr_cnt            <= wr_cnt + 1'b1;
                                end
                            end
                        end else begin
                            byte_phase <= 1'b0;
                            if (href_prev) begin
                                if (cam_row != '1) cam_row <= cam_row + 1'b1;
                                cam_col <= '0;
`ifdef CAM_LINE_CHECK_EN
                                // cam_col counts completed pixels of this href period
                                if (cam_col != c_col_lim) line_err <= 1'b1;
`endif
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (pclk_rise_c) href_prev <= href_s2;
`ifdef CAM_LINE_CHECK_EN
            if (vsync_fall_c) line_err <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a scaled 64x16 camera (8x2 image, 16 buffer words).
`timescale 1ns/1ps
module tb_ov7670_capture;
    logic        clk;
    logic        rst;
    logic        cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    logic        rgbmode, testmode;
    logic        frame_done, capturing;
`ifdef CAM_LINE_CHECK_EN
    logic        line_err;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_cnt = 0;
    logic [12:0] addr_q[$];
    logic [11:0] pix_q[$];

    ov7670_capture_if fb();

    ov7670_capture #(.c_cam_cols(64), .c_cam_rows(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .rgbmode   (rgbmode),
        .testmode  (testmode),
        .fb        (fb.master),
        .frame_done(frame_done),
        .capturing (capturing)
`ifdef CAM_LINE_CHECK_EN
        ,
        .line_err  (line_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/frame_done monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (fb.frame_we === 1'b1) begin
            addr_q.push_back(fb.frame_wr_addr);
            pix_q.push_back(fb.frame_wr_pixel);
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    // One camera byte: pclk low 2 clk, high 2 clk; called and returns at a negedge
    task automatic cam_byte(input logic [7:0] d, input logic h);
        cam_pclk = 1'b0; cam_data = d; cam_href = h;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cam_byte(8'h00, 1'b0);
    endtask

    task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < npix; i++) begin
            cam_byte(b0, 1'b1);
            cam_byte(b1, 1'b1);
        end
        idle(3);
    endtask

    task automatic end_frame();
        cam_vsync = 1'b1;
        idle(4);
    endtask

    task automatic start_frame();
        cam_vsync = 1'b0;
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        rgbmode = 1'b1; testmode = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (fb.frame_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", fb.frame_we); end
        n_tests++; if (fb.frame_wr_addr !== 13'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", fb.frame_wr_addr); end
        n_tests++; if (fb.frame_wr_pixel !== 12'h000) begin n_fail++; $display("FAIL reset_pixel got %h want 000", fb.frame_wr_pixel); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", frame_done); end
        n_tests++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL reset_capturing got %b want 0", capturing); end
`ifdef CAM_LINE_CHECK_EN
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL reset_line_err got %b want 0", line_err); end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rgb_frame();
        int base, d0, n;
        rgbmode = 1'b1; testmode = 1'b0;
        end_frame();
        d0 = done_cnt;
        start_frame();
        n_tests++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL rgb_capturing_start got %b want 1", capturing); end
        base = addr_q.size();
        for (int l = 0; l < 16; l++) send_line(64, 8'h0A, 8'hBC);
        n = addr_q.size() - base;
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL rgb_count got %0d want 16", n); end
        for (int i = 0; i < n; i++) begin
            n_tests++; if (addr_q[base+i] !== 13'(i)) begin n_fail++; $display("FAIL rgb_addr[%0d] got %0d want %0d", i, addr_q[base+i], i); end
            n_tests++; if (pix_q[base+i] !== 12'hABC) begin n_fail++; $display("FAIL rgb_pixel[%0d] got %h want abc", i, pix_q[base+i]); end
        end
`ifdef CAM_LINE_CHECK_EN
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL rgb_line_err got %b want 0", line_err); end
`endif
        n_tests++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL rgb_capturing_mid got %b want 1", capturing); end
        end_frame();
        n_tests++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rgb_frame_done got %0d want 1", done_cnt - d0); end
        n_tests++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL rgb_capturing_end got %b want 0", capturing); end
    endtask

    task automatic test_yuyv_switch();
        int base, n;
        rgbmode = 1'b0; testmode = 1'b0;
        start_frame();
        base = addr_q.size();
        for (int l = 0; l < 16; l++) begin
            if (l == 4) rgbmode = 1'b1;
            send_line(64, 8'h95, 8'h80);
        end
        end_frame();
        n = addr_q.size() - base;
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL yuyv_count got %0d want 16", n); end
        for (int i = 0; i < n; i++) begin
            n_tests++; if (pix_q[base+i] !== 12'h090) begin n_fail++; $display("FAIL yuyv_pixel[%0d] got %h want 090", i, pix_q[base+i]); end
        end
    endtask

    // rgbmode was raised mid-way through the previous frame; this frame is RGB and overlong
    task automatic test_overlong();
        int base, n;
        start_frame();
        base = addr_q.size();
        for (int l = 0; l < 20; l++) send_line(64, 8'h3C, 8'h5A);
        end_frame();
        n = addr_q.size() - base;
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL overlong_count got %0d want 16", n); end
        if (n > 0) begin
            n_tests++; if (addr_q[base+n-1] !== 13'd15) begin n_fail++; $display("FAIL overlong_last_addr got %0d want 15", addr_q[base+n-1]); end
        end
        for (int i = 0; i < n; i++) begin
            n_tests++; if (pix_q[base+i] !== 12'hC5A) begin n_fail++; $display("FAIL overlong_pixel[%0d] got %h want c5a", i, pix_q[base+i]); end
        end
    endtask

    task automatic test_testmode();
        int          base, n;
        int          idx [6] = '{0, 1, 2, 5, 7, 8};
        logic [11:0] exp [6] = '{12'hF00, 12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'hF00};
        rgbmode = 1'b1; testmode = 1'b1;
        start_frame();
        testmode = 1'b0;
        base = addr_q.size();
        for (int l = 0; l < 16; l++) send_line(64, 8'h0A, 8'hBC);
        end_frame();
        n = addr_q.size() - base;
        n_tests++; if (n !== 16) begin n_fail++; $display("FAIL test_count got %0d want 16", n); end
        for (int k = 0; k < 6; k++) begin
            if (idx[k] < n) begin
                n_tests++; if (pix_q[base+idx[k]] !== exp[k]) begin n_fail++; $display("FAIL testbar[%0d] got %h want %h", idx[k], pix_q[base+idx[k]], exp[k]); end
            end
        end
    endtask

    task automatic test_short_line();
        int base, n;
        rgbmode = 1'b1; testmode = 1'b0;
        start_frame();
        base = addr_q.size();
        send_line(48, 8'h0A, 8'hBC);
`ifdef CAM_LINE_CHECK_EN
        n_tests++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err_set got %b want 1", line_err); end
`endif
        for (int l = 1; l < 16; l++) send_line(64, 8'h0A, 8'hBC);
        end_frame();
        n = addr_q.size() - base;
        n_tests++; if (n !== 14) begin n_fail++; $display("FAIL short_count got %0d want 14", n); end
`ifdef CAM_LINE_CHECK_EN
        n_tests++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err_sticky got %b want 1", line_err); end
`endif
        start_frame();
`ifdef CAM_LINE_CHECK_EN
        n_tests++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL short_line_err_clear got %b want 0", line_err); end
`endif
        end_frame();
    endtask

    task automatic test_async_reset();
        int base, d0, n;
        rgbmode = 1'b1; testmode = 1'b0;
        start_frame();
        fork
            send_line(64, 8'h12, 8'h34);
            begin
                int k;
                k = 0;
                while (!(fb.frame_we === 1'b1 && fb.frame_wr_addr === 13'd3) && k < 400) begin
                    @(negedge clk);
                    k++;
                end
                n_tests++;
                if (k >= 400) begin
                    n_fail++; $display("FAIL arst_wait_we got timeout want frame_we");
                end else begin
                    rst = 1'b0;
                    #1;
                    n_tests++; if (fb.frame_we !== 1'b0) begin n_fail++; $display("FAIL arst_we got %b want 0", fb.frame_we); end
                    n_tests++; if (fb.frame_wr_addr !== 13'd0) begin n_fail++; $display("FAIL arst_addr got %0d want 0", fb.frame_wr_addr); end
                    n_tests++; if (fb.frame_wr_pixel !== 12'h000) begin n_fail++; $display("FAIL arst_pixel got %h want 000", fb.frame_wr_pixel); end
                    n_tests++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL arst_capturing got %b want 0", capturing); end
                end
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
        join
        d0 = done_cnt;
        base = addr_q.size();
        send_line(64, 8'h12, 8'h34);
        send_line(64, 8'h12, 8'h34);
        end_frame();
        n = addr_q.size() - base;
        n_tests++; if (n !== 0) begin n_fail++; $display("FAIL arst_partial_writes got %0d want 0", n); end
        n_tests++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL arst_partial_done got %0d want 0", done_cnt - d0); end
        start_frame();
        base = addr_q.size();
        send_line(64, 8'h0A, 8'hBC);
        end_frame();
        n = addr_q.size() - base;
        n_tests++; if (n !== 8) begin n_fail++; $display("FAIL arst_next_count got %0d want 8", n); end
        if (n > 0) begin
            n_tests++; if (addr_q[base] !== 13'd0) begin n_fail++; $display("FAIL arst_next_addr got %0d want 0", addr_q[base]); end
        end
    endtask

    initial begin
        test_reset();
        test_rgb_frame();
        test_yuyv_switch();
        test_overlong();
        test_testmode();
        test_short_line();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
